ahb_bram_ctrl: RTL and testbench

AHB-Lite slave controller that sits directly upstream of the SoC's dual-port block RAM (`Block_RAM`) and lets the e902 bus master read and write it. It maps address-phase and data-phase AHB transfers onto the RAM's synchronous write port A (byte-enabled) and registered read port B. Reads and writes complete with zero wait states. Read data is forwarded from a write that is still in its data phase, so back-to-back write→read to the same word returns the new data.

---
 rtl/ahb_bram_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite zero-wait slave in front of a dual-port block RAM (write port A, registered read port B).
// Read data is merged with a same-word write still in its data phase; illegal transfers get a two-cycle ERROR.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;
    logic [31:0]           fwd_data_q, fwd_data_d;

    logic                  accept;
    logic                  legal;
    logic [3:0]            lane_mask;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [31:0]           fwd_bits;
    logic                  unused_bits;

    assign unused_bits = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

    assign word_addr  = haddr[ADDR_WIDTH+1:2];
    assign bram_addrb = word_addr;
    assign bram_addra = addr_q;

    // ERR1 holds hreadyout low, so nothing is sampled there
    assign accept = hsel & htrans[1] & hready & (state_q != S_ERR1);

    always_comb begin
        lane_mask = 4'b0000;
        legal     = 1'b0;
        case (hsize)
            3'd0: begin
                lane_mask = 4'b0001 << haddr[1:0];
                legal     = 1'b1;
            end
            3'd1: begin
                lane_mask = 4'b0011 << haddr[1:0];
                legal     = ~haddr[0];
            end
            3'd2: begin
                lane_mask = 4'b1111;
                legal     = (haddr[1:0] == 2'b00);
            end
            default: begin
                lane_mask = 4'b0000;
                legal     = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mask_q     <= 4'b0000;
            fwd_mask_q <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = S_IDLE;
        addr_d     = addr_q;
        mask_d     = mask_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (accept) begin
            if (!legal) begin
                state_d = S_ERR1;
            end else if (hwrite) begin
                state_d = S_WR;
            end else begin
                state_d = S_RD;
            end
            addr_d     = word_addr;
            mask_d     = lane_mask;
            fwd_mask_d = 4'b0000;
            // RAM read port returns pre-write data on the commit edge, so capture the write lanes
            if (state_q == S_WR && legal && !hwrite && word_addr == addr_q) begin
                fwd_mask_d = mask_q;
                fwd_data_d = hwdata;
            end
        end
    end

    always_comb begin
        fwd_bits = 32'h0;
        for (int i = 0; i < 4; i++) begin
            fwd_bits[8*i +: 8] = {8{fwd_mask_q[i]}};
        end
    end

    // Outputs; forced to idle values while reset is asserted so a pending write is dropped
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = 32'h0;
        bram_wea  = 4'b0000;
        bram_dina = 32'h0;
        if (rst_n) begin
            case (state_q)
                S_WR: begin
                    bram_wea  = mask_q;
                    bram_dina = hwdata;
                end
                S_RD: begin
                    hrdata = (bram_doutb & ~fwd_bits) | (fwd_data_q & fwd_bits);
                end
                S_ERR1: begin
                    hreadyout = 1'b0;
                    hresp     = 1'b1;
                end
                S_ERR2: begin
                    hresp = 1'b1;
                end
                default: begin
                    hreadyout = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: table of AHB address phases with expected data-phase results,
// scoreboarded one cycle later against a read-first byte-enabled RAM model.
module tb_ahb_bram_ctrl;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [31:0]   hwdata;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [31:0]   hrdata;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;

    logic [31:0]   mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hready     (hready),
        .hreadyout  (hreadyout),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    // Read-first RAM model: port B sees the old word on the edge port A commits
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 | i;
        bram_doutb = 32'h0;
    end

    always @(posedge clk) begin
        bram_doutb <= mem[bram_addrb];
        for (int b = 0; b < 4; b++) begin
            if (bram_wea[b]) mem[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
        end
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy_in;
        logic [3:0]  e_wea;
        logic [31:0] e_rdata;
        logic        e_rdy;
        logic        e_resp;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  wea;
        logic [AW-1:0] addra;
        logic [31:0] dina;
        logic [31:0] rdata;
        logic        rdy;
        logic        resp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_wdata = 32'h0;

    localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                input logic rdy, input logic [3:0] ew, input logic [31:0] er,
                                input logic erdy, input logic eresp);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
        v.rdy_in = rdy; v.e_wea = ew; v.e_rdata = er; v.e_rdy = erdy; v.e_resp = eresp;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one address phase; compare the data phase of the previous one
    task automatic drive(input vec_t v, input int idx);
        exp_t e;
        exp_t n;
        @(posedge clk);
        #1;
        hsel   = v.sel;
        htrans = v.trans;
        hwrite = v.wr;
        hsize  = v.size;
        haddr  = v.addr;
        hready = v.rdy_in;
        hwdata = pend_wdata;
        pend_wdata = v.wdata;
        n.idx = idx; n.wea = v.e_wea; n.addra = v.addr[AW+1:2]; n.dina = v.wdata;
        n.rdata = v.e_rdata; n.rdy = v.e_rdy; n.resp = v.e_resp;
        @(negedge clk);
        chk("addrb", idx, 32'(bram_addrb), 32'(v.addr[AW+1:2]));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hreadyout", e.idx, 32'(hreadyout), 32'(e.rdy));
            chk("hresp", e.idx, 32'(hresp), 32'(e.resp));
            chk("wea", e.idx, 32'(bram_wea), 32'(e.wea));
            chk("hrdata", e.idx, hrdata, e.rdata);
            if (e.wea != 4'b0000) begin
                chk("addra", e.idx, 32'(bram_addra), 32'(e.addra));
                chk("dina", e.idx, bram_dina, e.dina);
            end
        end
        exp_q.push_back(n);
    endtask

    vec_t tbl[27];
    vec_t errseq[7];

    initial begin
        tbl[0]  = mk(1, NS, 0, 2, 32'h400, 32'h0,        1, 4'h0, 32'hC0DE0100, 1, 0);
        tbl[1]  = mk(1, NS, 1, 2, 32'h100, 32'hDEADBEEF, 1, 4'hF, 32'h0,        1, 0);
        tbl[2]  = mk(1, ID, 0, 0, 32'h0,   32'h0,        1, 4'h0, 32'h0,        1, 0);
        tbl[3]  = mk(1, NS, 0, 2, 32'h100, 32'h0,        1, 4'h0, 32'hDEADBEEF, 1, 0);
        tbl[4]  = mk(1, NS, 1, 2, 32'h200, 32'h11223344, 1, 4'hF, 32'h0,        1, 0);
        tbl[5]  = mk(1, NS, 1, 0, 32'h201, 32'h0000AA00, 1, 4'h2, 32'h0,        1, 0);
        tbl[6]  = mk(1, NS, 1, 1, 32'h202, 32'hBBCC0000, 1, 4'hC, 32'h0,        1, 0);
        tbl[7]  = mk(1, NS, 0, 2, 32'h200, 32'h0,        1, 4'h0, 32'hBBCCAA44, 1, 0);
        tbl[8]  = mk(1, NS, 0, 2, 32'h200, 32'h0,        1, 4'h0, 32'hBBCCAA44, 1, 0);
        tbl[9]  = mk(1, NS, 1, 2, 32'h300, 32'h0,        1, 4'hF, 32'h0,        1, 0);
        tbl[10] = mk(1, ID, 0, 0, 32'h0,   32'h0,        1, 4'h0, 32'h0,        1, 0);
        tbl[11] = mk(1, NS, 1, 0, 32'h303, 32'h5A000000, 1, 4'h8, 32'h0,        1, 0);
        tbl[12] = mk(1, NS, 0, 2, 32'h300, 32'h0,        1, 4'h0, 32'h5A000000, 1, 0);
        tbl[13] = mk(1, NS, 1, 2, 32'h300, 32'h12345678, 1, 4'hF, 32'h0,        1, 0);
        tbl[14] = mk(1, NS, 0, 2, 32'h304, 32'h0,        1, 4'h0, 32'hC0DE00C1, 1, 0);
        tbl[15] = mk(1, NS, 0, 2, 32'h300, 32'h0,        1, 4'h0, 32'h12345678, 1, 0);
        tbl[16] = mk(0, NS, 1, 2, 32'h300, 32'hFFFFFFFF, 1, 4'h0, 32'h0,        1, 0);
        tbl[17] = mk(1, BZ, 1, 2, 32'h300, 32'hFFFFFFFF, 1, 4'h0, 32'h0,        1, 0);
        tbl[18] = mk(1, NS, 1, 2, 32'h300, 32'hFFFFFFFF, 0, 4'h0, 32'h0,        1, 0);
        tbl[19] = mk(1, NS, 0, 2, 32'h300, 32'h0,        1, 4'h0, 32'h12345678, 1, 0);
        tbl[20] = mk(1, NS, 1, 2, 32'h500, 32'h01010101, 1, 4'hF, 32'h0,        1, 0);
        tbl[21] = mk(1, SQ, 1, 2, 32'h504, 32'h02020202, 1, 4'hF, 32'h0,        1, 0);
        tbl[22] = mk(1, SQ, 0, 2, 32'h500, 32'h0,        1, 4'h0, 32'h01010101, 1, 0);
        tbl[23] = mk(1, SQ, 0, 2, 32'h504, 32'h0,        1, 4'h0, 32'h02020202, 1, 0);
        tbl[24] = mk(1, NS, 1, 1, 32'h506, 32'h77660000, 1, 4'hC, 32'h0,        1, 0);
        tbl[25] = mk(1, SQ, 0, 2, 32'h504, 32'h0,        1, 4'h0, 32'h77660202, 1, 0);
        tbl[26] = mk(1, ID, 0, 0, 32'h0,   32'h0,        1, 4'h0, 32'h0,        1, 0);

        errseq[0] = mk(1, NS, 0, 2, 32'h002, 32'h0,        1, 4'h0, 32'h0,        0, 1);
        errseq[1] = mk(1, ID, 0, 0, 32'h0,   32'h0,        0, 4'h0, 32'h0,        1, 1);
        errseq[2] = mk(1, NS, 0, 2, 32'h100, 32'h0,        1, 4'h0, 32'hDEADBEEF, 1, 0);
        errseq[3] = mk(1, NS, 1, 1, 32'h005, 32'hFFFFFFFF, 1, 4'h0, 32'h0,        0, 1);
        errseq[4] = mk(1, ID, 0, 0, 32'h0,   32'h0,        0, 4'h0, 32'h0,        1, 1);
        errseq[5] = mk(1, NS, 0, 2, 32'h004, 32'h0,        1, 4'h0, 32'hC0DE0001, 1, 0);
        errseq[6] = mk(1, ID, 0, 0, 32'h0,   32'h0,        1, 4'h0, 32'h0,        1, 0);

        // Reset held with a write presented: nothing reaches the RAM
        rst_n  = 1'b0;
        hsel   = 1'b1;
        htrans = NS;
        hwrite = 1'b1;
        hsize  = 3'd2;
        haddr  = 32'h400;
        hwdata = 32'hFFFFFFFF;
        hready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_wea", c, 32'(bram_wea), 32'h0);
            chk("rst_hreadyout", c, 32'(hreadyout), 32'h1);
            chk("rst_hresp", c, 32'(hresp), 32'h0);
            chk("rst_hrdata", c, hrdata, 32'h0);
            chk("rst_addrb", c, 32'(bram_addrb), 32'h100);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        htrans = ID;
        hwrite = 1'b0;
        @(negedge clk);
        chk("post_rst_wea", 0, 32'(bram_wea), 32'h0);
        chk("post_rst_addra", 0, 32'(bram_addra), 32'h0);
        chk("post_rst_dina", 0, bram_dina, 32'h0);

        for (int i = 0; i < 27; i++) drive(tbl[i], i);
        for (int i = 0; i < 7; i++) drive(errseq[i], 100 + i);
        drive(mk(1, ID, 0, 0, 32'h0, 32'h0, 1, 4'h0, 32'h0, 1, 0), 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
